// File: rtl/default_chan_block_tx_framer.sv
// TX framer: parses a header word per packet, inserts HOLD/SOB/EOB tag words around
// the payload and drives the result through a registered two-entry skid output stage.
package rwt_tag_pkg;
   localparam logic [6:0] RWT_TAG_HOLD = 7'h01;
   localparam logic [6:0] RWT_TAG_SOB  = 7'h02;
   localparam logic [6:0] RWT_TAG_EOB  = 7'h03;
endpackage

module default_chan_block_tx_framer
   import rwt_tag_pkg::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cfg_hold_enabled,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [63:0]          s_data,
   input  logic                 s_last,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [63:0]          m_data,
   output logic                 m_tag_valid,
   output logic [6:0]           m_tag_type,
   output logic [CNT_WIDTH-1:0] burst_count,
   output logic [CNT_WIDTH-1:0] underflow_count,
   output logic                 fmt_error
);

   typedef enum logic [2:0] {S_HDR, S_HOLD, S_SOB, S_DATA, S_EOB} state_t;

   state_t               state_q, state_d, after_tags;
   logic                 in_burst_q, in_burst_d;
   logic                 eob_q, eob_d;
   logic                 empty_q, empty_d;
   logic [55:0]          ts_q, ts_d;
   logic [CNT_WIDTH-1:0] burst_q, burst_d;
   logic [CNT_WIDTH-1:0] under_q, under_d;
   logic                 fmt_q, fmt_d;
   logic                 run_q;

   logic                 out_valid_q, out_valid_d;
   logic [63:0]          out_data_q, out_data_d;
   logic                 out_tag_q, out_tag_d;
   logic [6:0]           out_type_q, out_type_d;
   logic                 skid_valid_q, skid_valid_d;
   logic [63:0]          skid_data_q, skid_data_d;
   logic                 skid_tag_q, skid_tag_d;
   logic [6:0]           skid_type_q, skid_type_d;

   logic                 in_valid, in_tag, push_ok, push, s_ready_w;
   logic [6:0]           in_type;
   logic [63:0]          in_data;
   logic                 unused_hdr_bits;

   // Only registered terms gate acceptance, so m_ready never reaches s_ready.
   assign push_ok   = run_q && !skid_valid_q;
   assign s_ready_w = push_ok && (state_q == S_HDR || state_q == S_DATA);
   assign push      = in_valid && push_ok;
   assign unused_hdr_bits = ^s_data[61:56];

   always_comb begin
      state_d    = state_q;
      in_burst_d = in_burst_q;
      eob_d      = eob_q;
      empty_d    = empty_q;
      ts_d       = ts_q;
      burst_d    = burst_q;
      under_d    = under_q;
      fmt_d      = fmt_q;
      in_valid   = 1'b0;
      in_tag     = 1'b0;
      in_type    = '0;
      in_data    = '0;
      after_tags = empty_q ? (eob_q ? S_EOB : S_HDR) : S_DATA;
      case (state_q)
         S_HDR: begin
            if (s_valid && s_ready_w) begin
               eob_d   = s_data[62];
               ts_d    = s_data[55:0];
               empty_d = s_last;
               if (s_last)
                  fmt_d = 1'b1;
               if (s_data[63] && cfg_hold_enabled)
                  state_d = S_HOLD;
               else if (!in_burst_q)
                  state_d = S_SOB;
               else if (s_last)
                  state_d = s_data[62] ? S_EOB : S_HDR;
               else
                  state_d = S_DATA;
            end
         end
         S_HOLD: begin
            in_valid = 1'b1;
            in_tag   = 1'b1;
            in_type  = RWT_TAG_HOLD;
            in_data  = {8'd0, ts_q};
            if (push_ok)
               state_d = in_burst_q ? after_tags : S_SOB;
         end
         S_SOB: begin
            in_valid = 1'b1;
            in_tag   = 1'b1;
            in_type  = RWT_TAG_SOB;
            if (push_ok) begin
               in_burst_d = 1'b1;
               burst_d    = burst_q + 1'b1;
               state_d    = after_tags;
            end
         end
         S_DATA: begin
            in_valid = s_valid;
            in_data  = s_data;
            if (s_valid && push_ok && s_last)
               state_d = eob_q ? S_EOB : S_HDR;
         end
         S_EOB: begin
            in_valid = 1'b1;
            in_tag   = 1'b1;
            in_type  = RWT_TAG_EOB;
            if (push_ok) begin
               in_burst_d = 1'b0;
               state_d    = S_HDR;
            end
         end
         default: state_d = S_HDR;
      endcase
      // Starvation: host owes us data but nothing is queued toward the DAC.
      if (in_burst_q && (state_q == S_HDR || state_q == S_DATA) && !s_valid &&
          !out_valid_q && (under_q != '1))
         under_d = under_q + 1'b1;
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_tag_d    = out_tag_q;
      out_type_d   = out_type_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_tag_d   = skid_tag_q;
      skid_type_d  = skid_type_q;
      if (!out_valid_q || m_ready) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            out_tag_d    = skid_tag_q;
            out_type_d   = skid_type_q;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = push;
            if (push) begin
               out_data_d = in_data;
               out_tag_d  = in_tag;
               out_type_d = in_type;
            end
         end
      end else if (push) begin
         skid_valid_d = 1'b1;
         skid_data_d  = in_data;
         skid_tag_d   = in_tag;
         skid_type_d  = in_type;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_HDR;
         in_burst_q   <= 1'b0;
         eob_q        <= 1'b0;
         empty_q      <= 1'b0;
         ts_q         <= '0;
         burst_q      <= '0;
         under_q      <= '0;
         fmt_q        <= 1'b0;
         run_q        <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_tag_q    <= 1'b0;
         out_type_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_tag_q   <= 1'b0;
         skid_type_q  <= '0;
      end else begin
         state_q      <= state_d;
         in_burst_q   <= in_burst_d;
         eob_q        <= eob_d;
         empty_q      <= empty_d;
         ts_q         <= ts_d;
         burst_q      <= burst_d;
         under_q      <= under_d;
         fmt_q        <= fmt_d;
         run_q        <= 1'b1;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_tag_q    <= out_tag_d;
         out_type_q   <= out_type_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_tag_q   <= skid_tag_d;
         skid_type_q  <= skid_type_d;
      end
   end

   assign s_ready         = s_ready_w;
   assign m_valid         = out_valid_q;
   assign m_data          = out_data_q;
   assign m_tag_valid     = out_tag_q;
   assign m_tag_type      = out_type_q;
   assign burst_count     = burst_q;
   assign underflow_count = under_q;
   assign fmt_error       = fmt_q;

endmodule

// File: tb/tb_default_chan_block_tx_framer.sv
// Scoreboard bench for the TX framer: stimulus pushes expected words, a negedge
// monitor pops and compares each output transfer and checks stall stability.
`timescale 1ns/1ps
module tb_default_chan_block_tx_framer;
   import rwt_tag_pkg::*;

   localparam int CW = 6;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          cfg_hold_enabled = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_last = 1'b0;
   logic [63:0]   s_data = '0;
   logic          m_ready = 1'b1;
   logic          s_ready, m_valid, m_tag_valid, fmt_error;
   logic [63:0]   m_data;
   logic [6:0]    m_tag_type;
   logic [CW-1:0] burst_count, underflow_count;

   typedef struct packed {
      logic        tag;
      logic [6:0]  typ;
      logic [63:0] data;
   } exp_t;

   exp_t          sb[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   int            n_out = 0;
   bit            bp_en = 1'b0;
   logic          m_in_burst = 1'b0;
   logic [CW-1:0] m_bursts = '0;
   logic          m_fmt = 1'b0;
   bit            stall_pend = 1'b0;
   exp_t          stall_val;

   always #5 clk = ~clk;

   default_chan_block_tx_framer #(.CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .cfg_hold_enabled(cfg_hold_enabled),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_tag_valid(m_tag_valid), .m_tag_type(m_tag_type),
      .burst_count(burst_count), .underflow_count(underflow_count),
      .fmt_error(fmt_error)
   );

   function automatic exp_t mk(input logic tag, input logic [6:0] typ, input logic [63:0] data);
      exp_t e;
      e.tag  = tag;
      e.typ  = typ;
      e.data = data;
      return e;
   endfunction

   initial forever begin
      @(posedge clk);
      #1;
      m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   initial begin : monitor
      exp_t got, e;
      forever begin
         @(negedge clk);
         got = {m_tag_valid, m_tag_type, m_data};
         if (reset) begin
            stall_pend = 1'b0;
         end else begin
            if (stall_pend) begin
               n_cmp++;
               if (!m_valid || got !== stall_val) begin
                  n_bad++;
                  $display("FAIL hold_stable: got valid=%0b word=%h, required held word=%h",
                           m_valid, got, stall_val);
               end
            end
            if (m_valid && m_ready) begin
               stall_pend = 1'b0;
               n_out++;
               n_cmp++;
               if (sb.size() == 0) begin
                  n_bad++;
                  $display("FAIL unexpected_out: got tag=%0b type=%0h data=%h, required nothing",
                           got.tag, got.typ, got.data);
               end else begin
                  e = sb.pop_front();
                  if (got.tag !== e.tag || got.data !== e.data || (e.tag && got.typ !== e.typ)) begin
                     n_bad++;
                     $display("FAIL out_word %0d: got tag=%0b type=%0h data=%h, required tag=%0b type=%0h data=%h",
                              n_out, got.tag, got.typ, got.data, e.tag, e.typ, e.data);
                  end else begin
                     $display("out %0d: tag=%0b type=%0h data=%h", n_out, got.tag, got.typ, got.data);
                  end
               end
            end else begin
               stall_pend = m_valid;
               stall_val  = got;
            end
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end else begin
         $display("check %s = %0h", name, act);
      end
   endtask

   task automatic send_word(input logic [63:0] d, input logic last);
      int t = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      @(negedge clk);
      while (!s_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!s_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: word %h not accepted in %0d cycles, required acceptance", d, t);
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_pkt(input bit ht, input bit eob, input logic [55:0] ts, input int n,
                           input logic [63:0] base, input bit hold);
      if (ht && hold)
         sb.push_back(mk(1'b1, RWT_TAG_HOLD, {8'd0, ts}));
      if (!m_in_burst) begin
         sb.push_back(mk(1'b1, RWT_TAG_SOB, 64'd0));
         m_in_burst = 1'b1;
         m_bursts   = m_bursts + 1'b1;
      end
      for (int i = 0; i < n; i++)
         sb.push_back(mk(1'b0, 7'd0, base + 64'(i) * 64'h0001_0001_0001_0001));
      if (eob) begin
         sb.push_back(mk(1'b1, RWT_TAG_EOB, 64'd0));
         m_in_burst = 1'b0;
      end
      if (n == 0)
         m_fmt = 1'b1;
      cfg_hold_enabled = hold;
      send_word({ht, eob, 6'b101010, ts}, n == 0);
      cfg_hold_enabled = !hold;
      for (int i = 0; i < n; i++)
         send_word(base + 64'(i) * 64'h0001_0001_0001_0001, i == n - 1);
   endtask

   task automatic drain(input string name);
      int t = 0;
      while ((sb.size() != 0 || m_valid) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (sb.size() != 0 || m_valid) begin
         n_bad++;
         $display("FAIL %s_drain: %0d words outstanding, required 0", name, sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sb.delete();
      m_in_burst = 1'b0;
      m_bursts   = '0;
      m_fmt      = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_m_tag_valid", 64'(m_tag_valid), 64'd0);
      check("rst_m_tag_type", 64'(m_tag_type), 64'd0);
      check("rst_m_data", m_data, 64'd0);
      check("rst_s_ready", 64'(s_ready), 64'd0);
      check("rst_burst_count", 64'(burst_count), 64'd0);
      check("rst_underflow", 64'(underflow_count), 64'd0);
      check("rst_fmt_error", 64'(fmt_error), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin : stim
      int u0;
      int words;
      int n;
      logic [63:0] r;
      #1;
      do_reset();

      // Timed header with hold enabled, two samples, no eob
      send_pkt(1'b1, 1'b0, 56'h1000, 2, 64'hA000_0000_0000_0001, 1'b1);
      drain("hold_sob");
      check("bursts_after_first", 64'(burst_count), 64'd1);
      check("fmt_after_first", 64'(fmt_error), 64'd0);

      // In-burst packet with eob: samples then EOB, no SOB
      send_pkt(1'b0, 1'b1, 56'h0, 3, 64'hB000_0000_0000_0010, 1'b0);
      drain("eob_pkt");
      check("bursts_after_eob", 64'(burst_count), 64'd1);

      // Header-only packet with eob while idle: SOB, EOB, fmt_error
      send_pkt(1'b0, 1'b1, 56'h0, 0, 64'd0, 1'b0);
      drain("empty_pkt");
      check("fmt_after_empty", 64'(fmt_error), 64'd1);
      check("bursts_after_empty", 64'(burst_count), 64'd2);

      // Underflow counting and saturation
      do_reset();
      send_pkt(1'b0, 1'b0, 56'h0, 1, 64'hC000_0000_0000_0100, 1'b0);
      drain("under_start");
      repeat (2) @(negedge clk);
      u0 = int'(underflow_count);
      repeat (5) @(negedge clk);
      check("underflow_plus5", 64'(underflow_count), 64'(u0 + 5));
      repeat (70) @(negedge clk);
      check("underflow_saturate", 64'(underflow_count), 64'h3F);
      @(posedge clk);
      #1;

      // Empty in-burst packet with hold and eob: HOLD then EOB only
      send_pkt(1'b1, 1'b1, 56'h00DE_AD00_BEEF, 0, 64'd0, 1'b1);
      drain("empty_hold");
      check("fmt_empty_hold", 64'(fmt_error), 64'd1);
      check("bursts_empty_hold", 64'(burst_count), 64'd1);

      // has_time with hold disabled: no HOLD tag, new burst
      send_pkt(1'b1, 1'b0, 56'h0012_3456, 2, 64'hD000_0000_0000_0200, 1'b0);
      send_pkt(1'b0, 1'b0, 56'h0, 0, 64'd0, 1'b0);
      send_pkt(1'b0, 1'b1, 56'h0, 1, 64'hE000_0000_0000_0300, 1'b1);
      drain("no_hold");
      check("bursts_no_hold", 64'(burst_count), 64'd2);

      // Reset after the 2nd sample of a 4-sample eob packet
      sb.push_back(mk(1'b1, RWT_TAG_SOB, 64'd0));
      sb.push_back(mk(1'b0, 7'd0, 64'hF000_0000_0000_0000));
      sb.push_back(mk(1'b0, 7'd0, 64'hF000_0000_0000_0001));
      cfg_hold_enabled = 1'b0;
      send_word({2'b01, 6'd0, 56'd0}, 1'b0);
      send_word(64'hF000_0000_0000_0000, 1'b0);
      send_word(64'hF000_0000_0000_0001, 1'b0);
      check("rst_pending_words", 64'(sb.size()), 64'd1);
      do_reset();
      send_pkt(1'b1, 1'b0, 56'h00AB_CDEF, 1, 64'h1234_5678_9ABC_DEF0, 1'b1);
      drain("post_reset");
      check("bursts_post_reset", 64'(burst_count), 64'd1);
      check("fmt_post_reset", 64'(fmt_error), 64'd0);

      // Random backpressure over at least 1000 words
      bp_en = 1'b1;
      words = 0;
      while (words < 1000) begin
         r = {$urandom(), $urandom()};
         n = $urandom_range(0, 8);
         send_pkt(r[63], r[62], r[55:0], n, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
         words += n + 1;
      end
      drain("random");
      bp_en = 1'b0;
      check("final_bursts_wrap", 64'(burst_count), 64'(m_bursts));
      check("final_fmt", 64'(fmt_error), 64'(m_fmt));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/default_chan_block_tx_framer.md
DEFAULT_CHAN_BLOCK_TX_FRAMER -- requirements
Module: default_chan_block_tx_framer

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32, the width of the status counters.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port cfg_hold_enabled, input, 1 bit: when set, timed headers produce a HOLD tag.
REQ-005 SHALL have port s_valid/s_ready/s_data/s_last, input/output/input/input, 1/1/64/1 bits: AXIS packet input from the host DMA.
REQ-006 SHALL have port m_valid/m_ready/m_data, output/input/output, 1/1/64 bits: tagged sample stream toward the DAC hold stage.
REQ-007 SHALL have port m_tag_valid/m_tag_type, output/output, 1/7 bits: qualifies m_data as a tag word and gives its type.
REQ-008 SHALL have port burst_count, output, CNT_WIDTH bits: number of SOB tags emitted, wrapping.
REQ-009 SHALL have port underflow_count, output, CNT_WIDTH bits: in-burst starvation cycles, saturating.
REQ-010 SHALL have port fmt_error, output, 1 bit: sticky; set by a packet with a zero-length payload.

Function
REQ-011 SHALL treat the first word of each packet as the header: bit63 = has_time, bit62 = eob, bits55:0 = timestamp; bits61:56 are ignored.
REQ-012 SHALL implement the FSM with states S_HDR, S_HOLD, S_SOB, S_DATA and S_EOB; reset state is S_HDR.
REQ-013 S_HDR SHALL accept one header word (s_ready=1 only when the output stage can accept) and latch its fields.
REQ-014 From S_HDR, the next state SHALL be S_HOLD if has_time and cfg_hold_enabled; else S_SOB if not in_burst; else S_DATA.
REQ-015 S_HOLD SHALL emit one tag word with type RWT_TAG_HOLD and data {8'd0, timestamp}, then go to S_SOB if not in_burst, else S_DATA.
REQ-016 S_SOB SHALL emit one tag word with type RWT_TAG_SOB and data 0, set in_burst, increment burst_count, then go to S_DATA.
REQ-017 S_DATA SHALL pass payload words with m_tag_valid=0 and data unmodified.
REQ-018 On the s_last beat in S_DATA, the next state SHALL be S_EOB if the header eob bit was set, else S_HDR.
REQ-019 S_EOB SHALL emit one tag word with type RWT_TAG_EOB and data 0, clear in_burst, then go to S_HDR.
REQ-020 Tag type codes SHALL be taken from the shared tag-type header constants RWT_TAG_HOLD, RWT_TAG_SOB and RWT_TAG_EOB; no literals.
REQ-021 s_ready SHALL be 0 in S_HOLD, S_SOB and S_EOB; input is stalled while tags are generated.
REQ-022 If a header beat has s_last=1 (empty packet), the block SHALL set fmt_error and emit the HOLD/SOB tags per REQ-014.
REQ-023 For an empty packet, the block SHALL skip S_DATA and go to S_EOB if eob is set, else to S_HDR.
REQ-024 Output SHALL pass through one registered skid stage: no combinational path s_valid->m_valid or m_ready->s_ready.
REQ-025 The output stage SHALL give one cycle of latency, full throughput (one word per cycle sustained in S_DATA), and no bubbles between packets other than tag cycles.
REQ-026 Once m_valid=1, m_data, m_tag_valid and m_tag_type SHALL hold stable until m_ready=1.
REQ-027 underflow_count SHALL increment, saturating at all-ones, on each cycle where in_burst=1, state is S_DATA or S_HDR, s_valid=0 and the output register is empty.
REQ-028 burst_count SHALL wrap modulo 2^CNT_WIDTH.
REQ-029 cfg_hold_enabled SHALL be sampled only at the header beat; changes mid-packet SHALL have no effect on that packet.

Reset
REQ-030 On reset assertion, the block SHALL asynchronously set state=S_HDR, in_burst=0, m_valid=0, m_tag_valid=0, m_tag_type=0, m_data=0, s_ready=0, burst_count=0, underflow_count=0 and fmt_error=0.
REQ-031 Reset asserted mid-packet SHALL discard the partial packet and any pending tag, with no EOB emitted.
REQ-032 After reset deassertion, the next accepted word SHALL be treated as a header.

Verification
REQ-033 Header 0x8000_0000_0000_1000 followed by 2 samples with last, eob=0, cfg_hold_enabled=1 -> HOLD(0x1000), SOB, 2 samples; burst_count=1.
REQ-034 Header 0x4000_0000_0000_0000 followed by 3 samples with last, in_burst=1 -> 3 samples then EOB; in_burst=0; no SOB.
REQ-035 Header-only packet with s_last=1 and eob=1 while idle -> SOB then EOB; fmt_error=1.
REQ-036 In burst, s_valid held low for 5 cycles with m_ready=1 -> underflow_count increases by 5.
REQ-037 Random m_ready backpressure over 1000 words -> output sequence equals the model's, with no data change while stalled.
REQ-038 Reset pulsed after the 2nd sample of a 4-sample packet -> all outputs zero; the next word is parsed as a header; no EOB is emitted.
